hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline stall/flush controller of the 5-stage CPU; the consumer of the forwarding unit's lw_stall.
//  Turns load-use stalls, taken branches and data-memory wait states into per-stage write enables and bubbles.
//  Adds a memory-wait FSM with timeout plus saturating performance counters. Sits beside the ID stage and drives all pipeline registers.
// PARAMETERS
//  MEM_TIMEOUT  16  max consecutive MEM_WAIT cycles before fatal error (>=2)
//  CNT_W        16  width of each performance counter
// PORTS
//  clk             in   1      clock, rising edge
//  rst             in   1      asynchronous active-high reset
//  lw_stall        in   1      load-use hazard from forwarding unit
//  branch_taken    in   1      EX resolved taken branch/jump
//  mem_req         in   1      MEM stage holds load/store this cycle
//  mem_ready       in   1      data memory completes access this cycle
//  pc_write        out  1      PC load enable
//  if_id_write     out  1      IF/ID load enable
//  id_ex_write     out  1      ID/EX load enable
//  ex_mem_write    out  1      EX/MEM load enable
//  if_id_flush     out  1      IF/ID loads NOP
//  id_ex_flush     out  1      ID/EX loads bubble (control bits 0)
//  mem_wb_flush    out  1      MEM/WB loads bubble
//  mem_timeout     out  1      sticky fatal flag
//  stall_cnt       out  CNT_W  load-use bubble cycles
//  flush_cnt       out  CNT_W  branch flush events
//  wait_cnt        out  CNT_W  memory freeze cycles
// BEHAVIOUR
//  States: RUN, MEM_WAIT, ERROR. Reset -> RUN; counters, mem_timeout, internal timer = 0.
//  While rst=1 all enables and flushes = 0, mem_timeout=0, counters 0.
//  Outputs combinational from state + inputs (same-cycle response); state/counters update on clk.
//  Priority in RUN and in MEM_WAIT with mem_ready=1: FREEZE > BRANCH > LOAD_USE > NORMAL.
//  FREEZE (RUN & mem_req & !mem_ready, or MEM_WAIT & !mem_ready): pc/if_id/id_ex/ex_mem writes=0,
//   if_id_flush=id_ex_flush=0, mem_wb_flush=1; lw_stall/branch_taken ignored (re-seen after release).
//  BRANCH: all writes=1, if_id_flush=1, id_ex_flush=1, mem_wb_flush=0; lw_stall ignored.
//  LOAD_USE: pc_write=0, if_id_write=0, id_ex_write=1, id_ex_flush=1, ex_mem_write=1, others 0.
//  NORMAL: all writes=1, all flushes=0.
//  Transitions: RUN->MEM_WAIT on FREEZE (timer:=1). MEM_WAIT: mem_ready=1 -> RUN (that cycle evaluated
//   as RUN minus FREEZE), timer:=0; else timer++; timer reaching MEM_TIMEOUT -> ERROR, mem_timeout:=1.
//  ERROR: all writes=0, all flushes=0, mem_timeout=1; exits only via rst.
//  Counters saturate at 2^CNT_W-1, never wrap: stall_cnt +1 per LOAD_USE cycle, flush_cnt +1 per
//   BRANCH cycle, wait_cnt +1 per FREEZE cycle. No counting in ERROR.
//  Reset mid-MEM_WAIT: immediate return to RUN, timer cleared, no spurious flush on release.
// TESTING
//  lw_stall=1 one cycle, no mem_req -> pc_write=0,if_id_write=0,id_ex_flush=1 that cycle; stall_cnt=1.
//  branch_taken=1 & lw_stall=1 same cycle -> if_id_flush=id_ex_flush=1, pc_write=1; flush_cnt=1, stall_cnt=0.
//  mem_req=1, mem_ready low 3 cycles then 1 -> 3 freeze cycles (writes 0, mem_wb_flush=1), wait_cnt=3, back in RUN.
//  mem_req=1, mem_ready=0 for MEM_TIMEOUT=16 cycles -> mem_timeout=1, all writes 0 until rst; rst clears.
//  CNT_W=4, 20 lw_stall cycles -> stall_cnt holds 15; rst asserted mid MEM_WAIT -> outputs 0, state RUN on release.

Source files
------------

// File: rtl/hazard_if.sv
// Pipeline hazard control bus: hazard sources in, stage enables/flushes and counters out.
interface hazard_if #(
  parameter int unsigned CNT_W = 16
);
  logic             lw_stall;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_write;
  logic             if_id_write;
  logic             id_ex_write;
  logic             ex_mem_write;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             mem_wb_flush;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] wait_cnt;

  // Hazard sources / observer side
  modport master (
    output lw_stall, branch_taken, mem_req, mem_ready,
    input  pc_write, if_id_write, id_ex_write, ex_mem_write,
    input  if_id_flush, id_ex_flush, mem_wb_flush, mem_timeout,
    input  stall_cnt, flush_cnt, wait_cnt
  );

  // Controller side
  modport slave (
    input  lw_stall, branch_taken, mem_req, mem_ready,
    output pc_write, if_id_write, id_ex_write, ex_mem_write,
    output if_id_flush, id_ex_flush, mem_wb_flush, mem_timeout,
    output stall_cnt, flush_cnt, wait_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush controller: load-use stalls, branch flushes, data-memory
// freeze with timeout, and saturating performance counters.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic     clk,
  input  logic     rst,
  hazard_if.slave  bus
);

  localparam int unsigned TW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  state_t           state;
  logic [TW-1:0]    timer;
  logic [TW-1:0]    timer_inc;
  logic             timeout_q;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;
  logic [CNT_W-1:0] wait_q;

  logic active;
  logic freeze;
  logic branch;
  logic load_use;

  // Classify this cycle: FREEZE > BRANCH > LOAD_USE > NORMAL, nothing in ERROR
  always_comb begin
    active    = (state != ERROR);
    freeze    = active && !bus.mem_ready &&
                ((state == RUN && bus.mem_req) || state == MEM_WAIT);
    branch    = active && !freeze && bus.branch_taken;
    load_use  = active && !freeze && !bus.branch_taken && bus.lw_stall;
    timer_inc = timer + TW'(1);
  end

  // Same-cycle stage enables and bubbles; everything held low during reset
  always_comb begin
    bus.pc_write     = 1'b0;
    bus.if_id_write  = 1'b0;
    bus.id_ex_write  = 1'b0;
    bus.ex_mem_write = 1'b0;
    bus.if_id_flush  = 1'b0;
    bus.id_ex_flush  = 1'b0;
    bus.mem_wb_flush = 1'b0;
    if (!rst && active) begin
      if (freeze) begin
        bus.mem_wb_flush = 1'b1;
      end else if (branch) begin
        bus.pc_write     = 1'b1;
        bus.if_id_write  = 1'b1;
        bus.id_ex_write  = 1'b1;
        bus.ex_mem_write = 1'b1;
        bus.if_id_flush  = 1'b1;
        bus.id_ex_flush  = 1'b1;
      end else if (load_use) begin
        bus.id_ex_write  = 1'b1;
        bus.ex_mem_write = 1'b1;
        bus.id_ex_flush  = 1'b1;
      end else begin
        bus.pc_write     = 1'b1;
        bus.if_id_write  = 1'b1;
        bus.id_ex_write  = 1'b1;
        bus.ex_mem_write = 1'b1;
      end
    end
  end

  // Memory-wait FSM with timeout timer, sticky fatal flag and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      timer     <= '0;
      timeout_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
      wait_q    <= '0;
    end else begin
      case (state)
        RUN: begin
          if (freeze) begin
            state <= MEM_WAIT;
            timer <= TW'(1);
          end
        end
        MEM_WAIT: begin
          if (bus.mem_ready) begin
            state <= RUN;
            timer <= '0;
          end else begin
            timer <= timer_inc;
            if (timer_inc == TW'(MEM_TIMEOUT)) begin
              state     <= ERROR;
              timeout_q <= 1'b1;
            end
          end
        end
        ERROR: begin
          state <= ERROR;
        end
        default: begin
          state <= RUN;
          timer <= '0;
        end
      endcase

      if (freeze && wait_q != '1)    wait_q  <= wait_q + CNT_W'(1);
      if (branch && flush_q != '1)   flush_q <= flush_q + CNT_W'(1);
      if (load_use && stall_q != '1) stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign bus.mem_timeout = timeout_q;
  assign bus.stall_cnt   = stall_q;
  assign bus.flush_cnt   = flush_q;
  assign bus.wait_cnt    = wait_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios then random traffic
// against a behavioural model tracking consecutive memory-wait cycles.
module tb_hazard_ctrl;

  localparam int unsigned MEM_TIMEOUT = 16;
  localparam int unsigned CNT_W       = 4;
  localparam int          CNT_MAX     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  hazard_if #(.CNT_W(CNT_W)) bus ();

  hazard_ctrl #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model: length of the current memory-wait run, dead flag, raw event counts
  int m_wait_len;
  bit m_dead;
  int m_stall;
  int m_flush;
  int m_wcnt;

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  function automatic bit m_freeze(input bit req, input bit rdy);
    return !m_dead && !rdy && (req || m_wait_len > 0);
  endfunction

  // Expected {pc, if_id, id_ex, ex_mem writes, if_id, id_ex, mem_wb flushes, timeout}
  function automatic logic [7:0] exp_ctl(input bit r, input bit lw, input bit br,
                                         input bit req, input bit rdy);
    if (r)                  return 8'b0000_000_0;
    if (m_dead)             return 8'b0000_000_1;
    if (m_freeze(req, rdy)) return 8'b0000_001_0;
    if (br)                 return 8'b1111_110_0;
    if (lw)                 return 8'b0011_010_0;
    return 8'b1111_000_0;
  endfunction

  function automatic logic [7:0] obs_ctl();
    return {bus.pc_write, bus.if_id_write, bus.id_ex_write, bus.ex_mem_write,
            bus.if_id_flush, bus.id_ex_flush, bus.mem_wb_flush, bus.mem_timeout};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input bit lw, input bit br,
                           input bit req, input bit rdy);
    check({tag, ".ctl"},   16'(obs_ctl()), 16'(exp_ctl(rst, lw, br, req, rdy)));
    check({tag, ".stall"}, 16'(bus.stall_cnt), 16'(sat(m_stall)));
    check({tag, ".flush"}, 16'(bus.flush_cnt), 16'(sat(m_flush)));
    check({tag, ".wait"},  16'(bus.wait_cnt),  16'(sat(m_wcnt)));
  endtask

  task automatic model_clear();
    m_wait_len = 0;
    m_dead     = 1'b0;
    m_stall    = 0;
    m_flush    = 0;
    m_wcnt     = 0;
  endtask

  // One clock: drive after the falling edge, check before the rising edge, advance model
  task automatic step(input string tag, input bit lw, input bit br, input bit req, input bit rdy);
    bus.lw_stall     = lw;
    bus.branch_taken = br;
    bus.mem_req      = req;
    bus.mem_ready    = rdy;
    #1;
    check_all(tag, lw, br, req, rdy);
    if (!m_dead) begin
      if (m_freeze(req, rdy)) begin
        m_wcnt++;
        m_wait_len++;
        if (m_wait_len == MEM_TIMEOUT) m_dead = 1'b1;
      end else begin
        m_wait_len = 0;
        if (br)      m_flush++;
        else if (lw) m_stall++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Asynchronous reset pulse starting mid-cycle
  task automatic do_reset(input string tag);
    rst = 1'b1;
    model_clear();
    #1;
    check_all(tag, bus.lw_stall, bus.branch_taken, bus.mem_req, bus.mem_ready);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst              = 1'b1;
    bus.lw_stall     = 1'b0;
    bus.branch_taken = 1'b0;
    bus.mem_req      = 1'b0;
    bus.mem_ready    = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Single load-use bubble
    step("lw1", 1'b1, 1'b0, 1'b0, 1'b1);
    step("lw1_after", 1'b0, 1'b0, 1'b0, 1'b1);

    // Branch wins over load-use in the same cycle
    step("br_lw", 1'b1, 1'b1, 1'b0, 1'b1);
    step("br_after", 1'b0, 1'b0, 1'b0, 1'b1);

    // Three-cycle memory freeze then release
    for (int i = 0; i < 3; i++) step("freeze3", 1'b1, 1'b1, 1'b1, 1'b0);
    step("release", 1'b0, 1'b0, 1'b1, 1'b1);
    step("post_release", 1'b0, 1'b0, 1'b0, 1'b1);

    // Load-use counter saturation
    for (int i = 0; i < 20; i++) step("lw_sat", 1'b1, 1'b0, 1'b0, 1'b1);
    step("lw_sat_end", 1'b0, 1'b0, 1'b0, 1'b1);

    // Memory timeout and sticky error until reset
    do_reset("rst_pre_timeout");
    for (int i = 0; i < MEM_TIMEOUT; i++) step("to_wait", 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step("to_error", 1'b1, 1'b1, 1'b1, 1'b1);
    do_reset("rst_error");
    step("after_error", 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of a memory wait; no flush after release
    for (int i = 0; i < 3; i++) step("wait_mid", 1'b0, 1'b0, 1'b1, 1'b0);
    do_reset("rst_mid_wait");
    step("no_spurious", 1'b0, 1'b0, 1'b0, 1'b0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) == 0) begin
        do_reset("rnd_rst");
      end else begin
        step("rnd",
             1'($urandom_range(99) < 30),
             1'($urandom_range(99) < 20),
             1'($urandom_range(99) < 35),
             1'($urandom_range(99) < 55));
      end
    end

    // Long not-ready run inside random traffic state
    for (int i = 0; i < MEM_TIMEOUT + 2; i++) step("rnd_to", 1'b0, 1'b0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
